// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

  // True when addr names a physically present entry.
  function automatic logic rf_addr_ok(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: source select (zero/range, write bypass, storage) and Q/QV registers.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int DEPTH   = 8,
  parameter int ZERO_R0 = 0,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] mem [DEPTH],
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  logic             addr_ok;
  logic             zero_hit;
  logic [WIDTH-1:0] rd_data;

  assign addr_ok  = rf_addr_ok(32'(addr), DEPTH);
  assign zero_hit = (ZERO_R0 != 0) && (addr == '0);

  // wr_en already excludes dropped writes, so a bypass never forwards discarded data.
  always_comb begin
    rd_data = '0;
    if (!addr_ok || zero_hit) begin
      rd_data = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (run && en) begin
      q  <= rd_data;
      qv <= 1'b1;
    end else begin
      qv <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// WIDTH x DEPTH register file with one write port, NRD registered read ports and a
// post-reset clear sequencer that zeroes every entry before accesses are accepted.
module reg_file_param
  import regfile_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int DEPTH   = 8,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 0,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                 CLKb,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     D,
  input  logic                 ENW,
  input  logic [AW-1:0]        WRA,
  input  logic [NRD-1:0]       ENR,
  input  logic [NRD*AW-1:0]    RDA,
  output logic [NRD*WIDTH-1:0] Q,
  output logic [NRD-1:0]       QV,
  output logic                 BUSY,
  output rf_state_t            dbg_state
);

  rf_state_t        state;
  logic [AW-1:0]    clr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             run;
  logic             wr_ok;

  assign run       = (state == RF_RUN);
  assign dbg_state = state;
  assign wr_ok     = run && !RST && ENW && rf_addr_ok(32'(WRA), DEPTH) &&
                     !((ZERO_R0 != 0) && (WRA == '0));

  // Clear sequencer: one entry per cycle, BUSY drops on the edge that clears the last entry.
  always_ff @(posedge CLKb) begin
    if (RST) begin
      state   <= RF_CLEAR;
      clr_ptr <= '0;
      BUSY    <= 1'b1;
    end else begin
      case (state)
        RF_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state <= RF_RUN;
            BUSY  <= 1'b0;
          end
        end
        RF_RUN: begin
          state <= RF_RUN;
        end
        default: begin
          state <= RF_CLEAR;
          BUSY  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLKb) begin
    if (!RST && (state == RF_CLEAR)) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[WRA] <= D;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ZERO_R0(ZERO_R0),
      .AW     (AW)
    ) u_port (
      .clk    (CLKb),
      .rst    (RST),
      .run    (run),
      .en     (ENR[k]),
      .addr   (RDA[k*AW +: AW]),
      .wr_en  (wr_ok),
      .wr_addr(WRA),
      .wr_data(D),
      .mem    (mem),
      .q      (Q[k*WIDTH +: WIDTH]),
      .qv     (QV[k])
    );
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: default, ZERO_R0=1 and DEPTH=6/NRD=3 instances against a behavioural model.
module tb_reg_file_param;
  import regfile_pkg::*;

  localparam int W = 10;

  typedef struct packed {
    logic [1:0]   dut;
    logic [1:0]   port;
    logic         v;
    logic [W-1:0] d;
  } exp_t;

  // clock / reset
  logic CLKb = 1'b0;
  always #5 CLKb = ~CLKb;
  logic RST;

  logic [W-1:0] din [3];
  logic         enw [3];
  logic [2:0]   wra [3];
  logic [2:0]   enr [3];
  logic [2:0]   rda [3][3];

  logic [2*W-1:0] q0, q1;
  logic [3*W-1:0] q2;
  logic [1:0]     qv0, qv1;
  logic [2:0]     qv2;
  logic           b0, b1, b2;
  rf_state_t      s0, s1, s2;

  reg_file_param u_dut0 (
    .CLKb(CLKb), .RST(RST), .D(din[0]), .ENW(enw[0]), .WRA(wra[0]),
    .ENR(enr[0][1:0]), .RDA({rda[0][1], rda[0][0]}),
    .Q(q0), .QV(qv0), .BUSY(b0), .dbg_state(s0)
  );

  reg_file_param #(.ZERO_R0(1)) u_dut1 (
    .CLKb(CLKb), .RST(RST), .D(din[1]), .ENW(enw[1]), .WRA(wra[1]),
    .ENR(enr[1][1:0]), .RDA({rda[1][1], rda[1][0]}),
    .Q(q1), .QV(qv1), .BUSY(b1), .dbg_state(s1)
  );

  reg_file_param #(.DEPTH(6), .NRD(3)) u_dut2 (
    .CLKb(CLKb), .RST(RST), .D(din[2]), .ENW(enw[2]), .WRA(wra[2]),
    .ENR(enr[2]), .RDA({rda[2][2], rda[2][1], rda[2][0]}),
    .Q(q2), .QV(qv2), .BUSY(b2), .dbg_state(s2)
  );

  // model and scoreboard
  int           depth_m [3] = '{8, 8, 6};
  int           nrd_m   [3] = '{2, 2, 3};
  int           zr_m    [3] = '{0, 1, 0};
  logic [W-1:0] mm [3][8];
  logic [W-1:0] qm [3][3];
  int           busy_cnt [3];
  exp_t         exp_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  string        phase = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  function automatic logic wr_ok_m(int d);
    return enw[d] && (int'(wra[d]) < depth_m[d]) && !(zr_m[d] != 0 && wra[d] == 3'd0);
  endfunction

  function automatic logic [W-1:0] read_m(int d, logic [2:0] a);
    if (int'(a) >= depth_m[d] || (zr_m[d] != 0 && a == 3'd0)) return '0;
    if (wr_ok_m(d) && wra[d] == a) return din[d];
    return mm[d][a];
  endfunction

  function automatic logic [W-1:0] get_q(int d, int p);
    case (d)
      0:       return q0[p*W +: W];
      1:       return q1[p*W +: W];
      default: return q2[p*W +: W];
    endcase
  endfunction

  function automatic logic get_qv(int d, int p);
    case (d)
      0:       return qv0[p];
      1:       return qv1[p];
      default: return qv2[p];
    endcase
  endfunction

  function automatic logic get_busy(int d);
    case (d)
      0:       return b0;
      1:       return b1;
      default: return b2;
    endcase
  endfunction

  // One clock: predict, update model, advance, then compare everything predicted.
  task automatic step();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < nrd_m[d]; p++) begin
        e.dut  = 2'(d);
        e.port = 2'(p);
        if (RST) begin
          qm[d][p] = '0;
          e.v = 1'b0;
        end else if (busy_cnt[d] == 0 && enr[d][p]) begin
          qm[d][p] = read_m(d, rda[d][p]);
          e.v = 1'b1;
        end else begin
          e.v = 1'b0;
        end
        e.d = qm[d][p];
        exp_q.push_back(e);
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (RST) begin
        busy_cnt[d] = depth_m[d];
        for (int i = 0; i < 8; i++) mm[d][i] = '0;
      end else if (busy_cnt[d] > 0) begin
        busy_cnt[d]--;
      end else if (wr_ok_m(d)) begin
        mm[d][wra[d]] = din[d];
      end
    end
    @(posedge CLKb);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("d%0d_q%0d", e.dut, e.port), 32'(get_q(e.dut, e.port)), 32'(e.d));
      check($sformatf("d%0d_qv%0d", e.dut, e.port), 32'(get_qv(e.dut, e.port)), 32'(e.v));
    end
    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d_busy", d), 32'(get_busy(d)), 32'(busy_cnt[d] != 0));
  endtask

  // driver tasks
  task automatic idle();
    for (int d = 0; d < 3; d++) begin
      enw[d] = 1'b0;
      enr[d] = '0;
    end
  endtask

  task automatic do_reset(input int clear_cycles);
    RST = 1'b1;
    step();
    RST = 1'b0;
    repeat (clear_cycles) step();
  endtask

  task automatic wr(input int d, input logic [2:0] a, input logic [W-1:0] v);
    enw[d] = 1'b1;
    wra[d] = a;
    din[d] = v;
  endtask

  task automatic rd(input int d, input int p, input logic [2:0] a);
    enr[d][p]    = 1'b1;
    rda[d][p] = a;
  endtask

  task automatic read_all(input int d);
    for (int a = 0; a < 8; a++) begin
      idle();
      for (int p = 0; p < nrd_m[d]; p++) rd(d, p, 3'(a));
      step();
    end
  endtask

  initial begin
    RST = 1'b0;
    for (int d = 0; d < 3; d++) begin
      din[d] = '0;
      wra[d] = '0;
      for (int p = 0; p < 3; p++) rda[d][p] = '0;
    end
    idle();
    @(negedge CLKb);

    phase = "reset";
    do_reset(8);
    read_all(0);
    read_all(2);

    phase = "write_read";
    idle(); wr(0, 3'd3, 10'h2A5); step();
    idle(); rd(0, 0, 3'd3); step();
    check("t2_q0", 32'(q0[W-1:0]), 32'h2A5);
    check("t2_qv1", 32'(qv0[1]), 32'h0);

    phase = "bypass";
    idle(); wr(0, 3'd5, 10'h155); rd(0, 1, 3'd5); step();
    check("t3_q1", 32'(q0[2*W-1:W]), 32'h155);
    idle(); rd(0, 0, 3'd5); step();
    check("t3_q0", 32'(q0[W-1:0]), 32'h155);

    phase = "random";
    for (int n = 0; n < 60; n++) begin
      for (int d = 0; d < 3; d++) begin
        enw[d] = 1'($urandom_range(0, 1));
        wra[d] = 3'($urandom_range(0, 7));
        din[d] = W'($urandom_range(0, 1023));
        enr[d] = 3'($urandom_range(0, 7));
        for (int p = 0; p < 3; p++) rda[d][p] = 3'($urandom_range(0, 7));
      end
      step();
    end

    phase = "reclear";
    for (int a = 0; a < 8; a++) begin
      idle(); wr(0, 3'(a), W'(a * 37 + 1)); step();
    end
    idle();
    do_reset(3);
    wr(0, 3'd2, 10'h3FF);
    do_reset(0);
    for (int n = 0; n < 8; n++) begin
      wr(0, 3'(n), 10'h1C3);
      rd(0, 0, 3'(n));
      check("t4_busy_held", 32'(b0), 32'h1);
      step();
    end
    read_all(0);

    phase = "zero_r0";
    idle(); wr(1, 3'd0, 10'h3FF); step();
    idle(); rd(1, 0, 3'd0); rd(1, 1, 3'd1); step();
    check("t5_q0", 32'(q1[W-1:0]), 32'h0);
    check("t5_qv0", 32'(qv1[0]), 32'h1);
    idle(); wr(1, 3'd0, 10'h2AA); rd(1, 0, 3'd0); step();
    check("t5_byp0", 32'(q1[W-1:0]), 32'h0);
    idle(); wr(1, 3'd1, 10'h0F0); rd(1, 1, 3'd1); step();

    phase = "depth6";
    idle(); wr(2, 3'd7, 10'h0AA); step();
    idle(); wr(2, 3'd2, 10'h123); for (int p = 0; p < 3; p++) rd(2, p, 3'd7); step();
    check("t6_q7", 32'(q2[W-1:0]), 32'h0);
    idle(); for (int p = 0; p < 3; p++) rd(2, p, 3'd2); step();
    for (int p = 0; p < 3; p++) check($sformatf("t6_same%0d", p), 32'(q2[p*W +: W]), 32'h123);
    idle(); step(); step();
    check("t6_hold", 32'(q2[2*W +: W]), 32'h123);
    check("t6_qv_low", 32'(qv2), 32'h0);
    idle(); wr(2, 3'd6, 10'h3C3); rd(2, 0, 3'd6); step();
    check("t6_byp6", 32'(q2[W-1:0]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
